and2_edge_counter: RTL and testbench

Registered event counter that consumes the output of a 2-input AND gate (the AND2 cell's Q output) and counts its rising edges. It sits directly downstream of the AND2 cell: the gate forms the qualifying condition A·B, and this block synchronises it, detects rising edges and counts them up to a terminal value. It reports completion with a valid/acknowledge handshake and flags events that are lost while a result is pending.

---
 rtl/and2_edge_counter.sv | 151 +++++++++++++++
 tb/tb_and2_edge_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/and2_edge_counter.sv
// -----------------------------------------------------------------------------
// and2_edge_counter
//
// Counts the rising edges of an AND2 gate output (D). D is asynchronous to the
// clock. It goes through a two-flop synchroniser and then one extra flop that
// is used for edge detection. Counting runs up to LIMIT. On reaching LIMIT the
// block raises V and holds it until ACK or CLR. While V is high, a further edge
// sets the sticky overrun flag OV.
//
// Parameters
//   N      counter width in bits
//   LIMIT  terminal count, 1 .. 2^N-1 (elaboration fails outside this range)
//
// Ports
//   C    in   clock, rising-edge active
//   R    in   asynchronous active-high reset
//   D    in   event input (AND2 Q), asynchronous to C
//   EN   in   count enable
//   CLR  in   synchronous clear (highest priority)
//   ACK  in   acknowledge of a completed count (only acts in DONE)
//   Q    out  current count (registered)
//   V    out  count complete, Q == LIMIT (registered)
//   OV   out  sticky overrun, edge seen while V=1 (registered)
// -----------------------------------------------------------------------------
module and2_edge_counter #(
   parameter int N     = 4,
   parameter int LIMIT = 10
) (
   input  logic         C,
   input  logic         R,
   input  logic         D,
   input  logic         EN,
   input  logic         CLR,
   input  logic         ACK,
   output logic [N-1:0] Q,
   output logic         V,
   output logic         OV
);

   // Refuse to build with a terminal count the counter cannot represent.
   generate
      if (LIMIT < 1 || LIMIT > (2**N) - 1) begin : g_bad_limit
         $error("and2_edge_counter: LIMIT out of range 1..2^N-1");
      end
   endgenerate

   localparam logic [N-1:0] LIMIT_Q  = N'(LIMIT);
   localparam logic [N-1:0] LIMIT_M1 = N'(LIMIT - 1);
   localparam logic [N-1:0] ONE_Q    = N'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // sync_reg[0] = s1, sync_reg[1] = s2, sync_reg[2] = s3
   logic [2:0]   sync_reg;
   logic         edge_stb;

   state_t       state_reg, state_next;
   logic [N-1:0] q_reg, q_next;
   logic         v_reg, v_next;
   logic         ov_reg, ov_next;

   // The synchroniser runs in every state, so a D level that is already high
   // when counting starts is not mistaken for a new edge.
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         sync_reg <= 3'b000;
      end else begin
         sync_reg <= {sync_reg[1:0], D};
      end
   end

   // One-cycle strobe per synchronised rising edge: s2 & ~s3.
   assign edge_stb = sync_reg[1] & ~sync_reg[2];

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state_reg <= ST_IDLE;
         q_reg     <= '0;
         v_reg     <= 1'b0;
         ov_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         q_reg     <= q_next;
         v_reg     <= v_next;
         ov_reg    <= ov_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      v_next     = v_reg;
      ov_next    = ov_reg;

      if (CLR) begin
         // Clear beats both the edge strobe and ACK.
         q_next     = '0;
         v_next     = 1'b0;
         ov_next    = 1'b0;
         state_next = EN ? ST_COUNT : ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (EN) begin
                  state_next = ST_COUNT;
               end
            end

            ST_COUNT: begin
               if (!EN) begin
                  // Pause: an edge in this cycle is dropped.
                  state_next = ST_IDLE;
               end else if (edge_stb) begin
                  if (q_reg == LIMIT_M1) begin
                     q_next     = LIMIT_Q;
                     v_next     = 1'b1;
                     state_next = ST_DONE;
                  end else begin
                     q_next = q_reg + ONE_Q;
                  end
               end
            end

            ST_DONE: begin
               if (ACK) begin
                  // An edge in the ACK cycle is dropped, not flagged.
                  q_next     = '0;
                  v_next     = 1'b0;
                  ov_next    = 1'b0;
                  state_next = EN ? ST_COUNT : ST_IDLE;
               end else if (edge_stb) begin
                  ov_next = 1'b1;
               end
            end

            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign Q  = q_reg;
   assign V  = v_reg;
   assign OV = ov_reg;

endmodule

// File: tb/tb_and2_edge_counter.sv
// -----------------------------------------------------------------------------
// tb_and2_edge_counter
//
// Directed bench for and2_edge_counter with N=4 and LIMIT=10. Inputs change
// 1 ns after a rising clock edge. Outputs are sampled at the same point, so
// each value seen is the state left by the edge just taken.
// -----------------------------------------------------------------------------
module tb_and2_edge_counter;

   logic       C = 1'b0;
   logic       R = 1'b1;
   logic       D = 1'b0;
   logic       EN = 1'b0;
   logic       CLR = 1'b0;
   logic       ACK = 1'b0;
   logic [3:0] Q;
   logic       V;
   logic       OV;

   int tests_run = 0;
   int tests_failed = 0;

   and2_edge_counter #(.N(4), .LIMIT(10)) dut (
      .C   (C),
      .R   (R),
      .D   (D),
      .EN  (EN),
      .CLR (CLR),
      .ACK (ACK),
      .Q   (Q),
      .V   (V),
      .OV  (OV)
   );

   always #5 C = ~C;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
         $display("[TB] check %-22s obs=%0d exp=%0d ok", tag, obs, exp);
      else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // D high for two samples, low for two samples. The increment lands on the
   // third edge, so the count is visible when the task returns.
   task automatic pulse();
      D = 1'b1;
      tick();
      tick();
      D = 1'b0;
      tick();
      tick();
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) pulse();
   endtask

   initial begin
      // ---- reset state ----
      tick();
      tick();
      chk("reset_q", 32'(Q), 0);
      chk("reset_v", 32'(V), 0);
      chk("reset_ov", 32'(OV), 0);
      @(negedge C);
      R = 1'b0;
      EN = 1'b1;
      tick();                       // IDLE -> COUNT

      // ---- latency: increment lands 3 edges after first high sample ----
      D = 1'b1;
      tick();                       // edge k
      chk("lat_k", 32'(Q), 0);
      tick();                       // edge k+1
      chk("lat_k1", 32'(Q), 0);
      D = 1'b0;
      tick();                       // edge k+2
      chk("lat_k2", 32'(Q), 1);
      tick();
      pulses(2);
      chk("basic_q3", 32'(Q), 3);
      chk("basic_v0", 32'(V), 0);

      // ---- terminal count ----
      pulses(6);
      chk("term_q9", 32'(Q), 9);
      D = 1'b1;
      tick();
      tick();
      chk("term_v_before", 32'(V), 0);
      D = 1'b0;
      tick();
      chk("term_q10", 32'(Q), 10);
      chk("term_v1", 32'(V), 1);
      tick();

      // ---- overrun in DONE ----
      D = 1'b1;
      tick();
      tick();
      chk("ov_before", 32'(OV), 0);
      D = 1'b0;
      tick();
      chk("ov_set", 32'(OV), 1);
      tick();
      pulse();
      chk("ov_q_held", 32'(Q), 10);
      chk("ov_sticky", 32'(OV), 1);
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      chk("ack_q", 32'(Q), 0);
      chk("ack_v", 32'(V), 0);
      chk("ack_ov", 32'(OV), 0);
      pulse();
      chk("ack_to_count", 32'(Q), 1);
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      chk("clr_q", 32'(Q), 0);

      // ---- pause and level-high enable ----
      pulses(4);
      chk("pause_q4", 32'(Q), 4);
      EN = 1'b0;
      tick();
      pulses(3);
      chk("pause_held", 32'(Q), 4);
      D = 1'b1;
      tick();
      tick();
      tick();
      EN = 1'b1;
      tick();
      tick();
      tick();
      chk("level_high", 32'(Q), 4);
      D = 1'b0;
      tick();
      tick();
      tick();
      pulse();
      chk("after_level", 32'(Q), 5);

      // ---- CLR together with an edge strobe ----
      D = 1'b1;
      tick();
      tick();                       // strobe is high until the next edge
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      D = 1'b0;
      chk("clr_e_q", 32'(Q), 0);
      tick();
      tick();
      chk("clr_e_later", 32'(Q), 0);

      // ---- CLR together with ACK in DONE ----
      pulses(10);
      chk("done2_v", 32'(V), 1);
      pulse();
      chk("done2_ov", 32'(OV), 1);
      CLR = 1'b1;
      ACK = 1'b1;
      tick();
      CLR = 1'b0;
      ACK = 1'b0;
      chk("clr_ack_q", 32'(Q), 0);
      chk("clr_ack_v", 32'(V), 0);
      chk("clr_ack_ov", 32'(OV), 0);

      // ---- edge in the ACK cycle ----
      pulses(10);
      chk("done3_q", 32'(Q), 10);
      D = 1'b1;
      tick();
      tick();
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      D = 1'b0;
      chk("ack_e_q", 32'(Q), 0);
      chk("ack_e_ov", 32'(OV), 0);
      tick();
      tick();
      chk("ack_e_later", 32'(Q), 0);

      // ---- short pulse between edges ----
      #2 D = 1'b1;
      #2 D = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("short_pulse", 32'(Q), 0);

      // ---- async reset mid-count ----
      pulses(7);
      chk("pre_rst_q7", 32'(Q), 7);
      D = 1'b1;
      tick();
      tick();                       // strobe pending when reset hits
      #3 R = 1'b1;
      #1;
      chk("async_rst_q", 32'(Q), 0);
      chk("async_rst_v", 32'(V), 0);
      D = 1'b0;
      @(negedge C);
      R = 1'b0;
      tick();
      chk("post_rst_q", 32'(Q), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
